// File: rtl/branch_insn_encoder_if.sv
// Handshake bundle for branch_insn_encoder.
//   Request side : in_valid/in_ready plus the branch description
//                  (in_funct3, in_rs1, in_rs2, in_offset).
//   Result side  : out_valid/out_ready plus the encoded word (out_insn)
//                  and its error code (out_err).
// slave  : the encoder's view (consumes requests, produces results).
// master : the environment's view (produces requests, consumes results).
interface branch_insn_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_offset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [1:0]  out_err;

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_offset, out_ready,
    output in_ready, out_valid, out_insn, out_err
  );

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_offset, out_ready,
    input  in_ready, out_valid, out_insn, out_err
  );
endinterface

// File: rtl/branch_insn_encoder.sv
// branch_insn_encoder: builds RV32I B-type instruction words from a branch
// description and queues them in a 2-entry output FIFO.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   bus       : branch_insn_encoder_if.slave (request and result handshakes)
//   err_count : saturating count of accepted requests carrying an error
// Illegal funct3 (010/011) and misaligned offsets are flagged in out_err and
// the stored word is forced to zero so a bad request never looks like a
// legal branch downstream.
module branch_insn_encoder #(
  parameter int IALIGN    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_insn_encoder_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  // bit0: reserved funct3 encoding, bit1: offset violates IALIGN
  function automatic logic [1:0] calc_err(input logic [2:0] f3, input logic [12:0] off);
    logic [1:0] e;
    e[0] = (f3 == 3'b010) || (f3 == 3'b011);
    if (IALIGN == 32) begin
      e[1] = (off[1:0] != 2'b00);
    end else begin
      e[1] = off[0];
    end
    return e;
  endfunction

  // B-type layout; off[0] is implicit and never stored
  function automatic logic [31:0] encode_b(input logic [2:0] f3, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  occ_e                 occ_q, occ_d;
  logic [31:0]          head_insn_q, head_insn_d;
  logic [1:0]           head_err_q, head_err_d;
  logic [31:0]          tail_insn_q, tail_insn_d;
  logic [1:0]           tail_err_q, tail_err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [1:0]  new_err_s;
  logic [31:0] new_insn_s;
  logic        push_s;
  logic        pop_s;

  assign new_err_s  = calc_err(bus.in_funct3, bus.in_offset);
  assign new_insn_s = (new_err_s != 2'b00) ? 32'h0000_0000
                      : encode_b(bus.in_funct3, bus.in_rs1, bus.in_rs2, bus.in_offset);
  assign push_s     = bus.in_valid & in_ready_q;
  assign pop_s      = out_valid_q & bus.out_ready;

  // Occupancy next-state, FIFO storage update and error counter
  always_comb begin
    occ_d       = occ_q;
    head_insn_d = head_insn_q;
    head_err_d  = head_err_q;
    tail_insn_d = tail_insn_q;
    tail_err_d  = tail_err_q;
    err_count_d = err_count_q;

    case (occ_q)
      OCC_EMPTY: begin
        if (push_s) begin
          head_insn_d = new_insn_s;
          head_err_d  = new_err_s;
          occ_d       = OCC_ONE;
        end else begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push_s && pop_s) begin
          // head leaves as the new word arrives: it becomes the head directly
          head_insn_d = new_insn_s;
          head_err_d  = new_err_s;
          occ_d       = OCC_ONE;
        end else if (push_s) begin
          tail_insn_d = new_insn_s;
          tail_err_d  = new_err_s;
          occ_d       = OCC_FULL;
        end else if (pop_s) begin
          // head keeps the departed word so outputs hold their last value
          occ_d = OCC_EMPTY;
        end else begin
          occ_d = OCC_ONE;
        end
      end
      OCC_FULL: begin
        // push cannot happen here because in_ready is low
        if (pop_s) begin
          head_insn_d = tail_insn_q;
          head_err_d  = tail_err_q;
          occ_d       = OCC_ONE;
        end else begin
          occ_d = OCC_FULL;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase

    if (push_s && (new_err_s != 2'b00) && (err_count_q != ERR_CNT_MAX)) begin
      err_count_d = err_count_q + ERR_CNT_ONE;
    end else begin
      err_count_d = err_count_q;
    end

    // handshake flags are registered from the next occupancy
    in_ready_d  = (occ_d != OCC_FULL);
    out_valid_d = (occ_d != OCC_EMPTY);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= OCC_EMPTY;
      head_insn_q <= 32'h0000_0000;
      head_err_q  <= 2'b00;
      tail_insn_q <= 32'h0000_0000;
      tail_err_q  <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_count_q <= {ERR_CNT_W{1'b0}};
    end else begin
      occ_q       <= occ_d;
      head_insn_q <= head_insn_d;
      head_err_q  <= head_err_d;
      tail_insn_q <= tail_insn_d;
      tail_err_q  <= tail_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_insn  = head_insn_q;
  assign bus.out_err   = head_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_branch_insn_encoder.sv
module tb_branch_insn_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] err_count;

  branch_insn_encoder_if bus ();

  branch_insn_encoder #(.IALIGN(32), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] insn;
    logic [1:0]  err;
  } entry_t;

  // reference model state: queued words, last displayed word, error count
  entry_t mq[$];
  entry_t m_last;
  int     m_errcnt;
  entry_t outs[$];   // every word the consumer has taken, in order

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] off;
    logic [31:0] insn;
    logic [1:0]  err;
  } vec_t;

  // Behavioural encoding: arithmetic on the integer offset
  function automatic entry_t ref_encode(int f3, int rs1, int rs2, int off);
    entry_t e;
    int     u;
    bit     bad_f3;
    bit     mis;
    u      = off & 8191;
    bad_f3 = !(f3 inside {0, 1, 4, 5, 6, 7});
    mis    = (u % 4) != 0;
    e.err  = {mis, bad_f3};
    if (bad_f3 || mis) begin
      e.insn = 32'h0;
    end else begin
      e.insn = 32'((u / 4096) % 2) * 32'h8000_0000
             + 32'((u / 32) % 64) * 32'h0200_0000
             + 32'(rs2) * 32'h0010_0000
             + 32'(rs1) * 32'h0000_8000
             + 32'(f3)  * 32'h0000_1000
             + 32'((u / 2) % 16) * 32'h0000_0100
             + 32'((u / 2048) % 2) * 32'h0000_0080
             + 32'd99;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int f3, input int rs1, input int rs2, input int off);
    bus.in_funct3 = 3'(f3);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_offset = 13'(off);
  endtask

  // One clock: compare DUT against model, take the edge, advance the model
  task automatic cycle();
    entry_t disp;
    entry_t cur;
    bit     acc;
    bit     pop;
    disp = (mq.size() > 0) ? mq[0] : m_last;
    chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    chk("out_insn",  bus.out_insn,       disp.insn);
    chk("out_err",   32'(bus.out_err),   32'(disp.err));
    chk("err_count", 32'(err_count),     32'(m_errcnt));
    acc = bus.in_valid && (mq.size() < 2);
    pop = (mq.size() > 0) && bus.out_ready;
    cur = ref_encode(int'(bus.in_funct3), int'(bus.in_rs1), int'(bus.in_rs2),
                     int'($signed(bus.in_offset)));
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_last   = '{32'h0, 2'b00};
      m_errcnt = 0;
    end else begin
      if (pop) begin
        m_last = mq.pop_front();
        outs.push_back(m_last);
      end
      if (acc) begin
        mq.push_back(cur);
        if (cur.err != 2'b00 && m_errcnt < 255) m_errcnt++;
      end
    end
    #1;
  endtask

  vec_t   vt[9];
  entry_t wa, wb, wc;
  int     exp_errs;

  initial begin
    vt[0] = '{3'b000, 5'd4,  5'd5,  13'h0008, 32'h0052_0463, 2'b00};
    vt[1] = '{3'b001, 5'd1,  5'd2,  13'h1FFC, 32'hFE20_9EE3, 2'b00};
    vt[2] = '{3'b010, 5'd1,  5'd2,  13'h0008, 32'h0000_0000, 2'b01};
    vt[3] = '{3'b000, 5'd1,  5'd2,  13'h0006, 32'h0000_0000, 2'b10};
    vt[4] = '{3'b011, 5'd3,  5'd3,  13'h0001, 32'h0000_0000, 2'b11};
    vt[5] = '{3'b100, 5'd31, 5'd0,  13'h0FFC, 32'h7E0F_CEE3, 2'b00};
    vt[6] = '{3'b111, 5'd7,  5'd9,  13'h1000, 32'h8093_F063, 2'b00};
    vt[7] = '{3'b101, 5'd0,  5'd0,  13'h0800, 32'h0000_50E3, 2'b00};
    vt[8] = '{3'b110, 5'd10, 5'd11, 13'h0020, 32'h02B5_6063, 2'b00};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_last   = '{32'h0, 2'b00};
    m_errcnt = 0;

    // reset state (the model checks in cycle() repeat these each clock)
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_insn",  bus.out_insn,       32'h0);
    chk("rst_err_count", 32'(err_count),     32'd0);
    cycle();

    // table vectors: one request, check one cycle later, then drain
    bus.out_ready = 1'b1;
    exp_errs = 0;
    for (int i = 0; i < 9; i++) begin
      set_req(int'(vt[i].f3), int'(vt[i].rs1), int'(vt[i].rs2), int'(vt[i].off));
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      if (vt[i].err != 2'b00) exp_errs++;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_insn", i),  bus.out_insn,       vt[i].insn);
      chk($sformatf("vec%0d_err", i),   32'(bus.out_err),   32'(vt[i].err));
      chk($sformatf("vec%0d_cnt", i),   32'(err_count),     32'(exp_errs));
      cycle();
    end

    // backpressure: three back-to-back requests with the consumer stalled
    wa = ref_encode(0, 1, 1, 16);
    wb = ref_encode(1, 2, 2, -32);
    wc = ref_encode(4, 3, 3, 64);
    outs.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_req(0, 1, 1, 16);  cycle();
    set_req(1, 2, 2, -32); cycle();
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    set_req(4, 3, 3, 64);
    cycle(); cycle();
    chk("bp_head_stable", bus.out_insn, wa.insn);
    chk("bp_still_full",  32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (k == 1) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    repeat (4) cycle();
    chk("bp_count", 32'(outs.size()), 32'd3);
    if (outs.size() == 3) begin
      chk("bp_order1", outs[0].insn, wa.insn);
      chk("bp_order2", outs[1].insn, wb.insn);
      chk("bp_order3", outs[2].insn, wc.insn);
    end

    // streaming: 10 requests, one per cycle, with the consumer always ready
    outs.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_req(5, k + 1, 20, 4 * k);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("stream_count", 32'(outs.size()), 32'd10);
    for (int k = 0; k < 10 && k < outs.size(); k++) begin
      chk("stream_rs1", 32'(outs[k].insn[19:15]), 32'(k + 1));
    end
    cycle();

    // error counter saturation at all-ones
    bus.in_valid = 1'b1;
    set_req(2, 0, 0, 0);
    for (int k = 0; k < 260; k++) cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("err_sat", 32'(err_count), 32'd255);

    // reset with a full FIFO discards both queued words
    outs.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_req(0, 6, 6, 8);  cycle();
    set_req(1, 7, 7, 12); cycle();
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("post_rst_err_count", 32'(err_count),     32'd0);
    chk("post_rst_out_insn",  bus.out_insn,       32'h0);
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("post_rst_no_words", 32'(outs.size()), 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      int off;
      off = int'($urandom_range(0, 8191));
      if ($urandom_range(0, 3) != 0) off = off & ~3;
      set_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), off);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_insn_encoder.md
Name:
branch_insn_encoder

Overview:
- Inverse of the B-type instruction decoder. Takes a branch description and produces the 32-bit RV32I B-type instruction word.
  - Branch description: condition code, source registers, signed byte offset.
- Used by the instruction-generation path: test program builder and boot-ROM loader. Its output feeds instruction memory and the decoder under test.
- Input and output both use valid/ready handshakes. A 2-entry output FIFO decouples them.
- Flags illegal requests. Counts errors.

Parameters:
- IALIGN, default 32: required instruction alignment in bits. 32 means offset[1:0] must be 00. 16 means only offset[0] must be 0.
- ERR_CNT_W, default 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_funct3  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- in_rs1  in  5  first source register
- in_rs2  in  5  second source register
- in_offset  in  13  signed byte offset (imm[12:0])
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_insn  out  32  encoded instruction
- out_err  out  2  error code for out_insn: 00 ok, 01 illegal funct3, 10 misaligned offset, 11 both
- err_count  out  ERR_CNT_W  number of erroneous requests accepted; saturates at all-ones

Behaviour:
- Reset (clk edge with reset=1):
  - FIFO emptied; out_valid=0; out_insn=0; out_err=00; err_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards every queued entry. No output is produced for them.
- Encoding (combinational on inputs, captured at accept):
  - insn[31] = off[12]
  - insn[30:25] = off[10:5]
  - insn[24:20] = rs2
  - insn[19:15] = rs1
  - insn[14:12] = funct3
  - insn[11:8] = off[4:1]
  - insn[7] = off[11]
  - insn[6:0] = 1100011
- Errors:
  - funct3 of 010 or 011 sets err bit0.
  - With IALIGN=32, offset[1:0]≠00 sets err bit1. With IALIGN=16, offset[0]=1 sets err bit1.
  - Any error forces the stored word to 32'h00000000. The err code is stored alongside it.
  - err_count increments by 1 for each accepted request with err≠00. It holds at max.
- Handshake:
  - Accept when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Inputs are sampled only on accept. Inputs on other cycles are don't-care.
- FIFO: 2 entries, occupancy state EMPTY(0) / ONE(1) / FULL(2).
  - in_ready = (occupancy != FULL). It is registered and does not depend on out_ready.
  - out_valid = (occupancy != EMPTY). out_insn and out_err always show the head entry and stay stable while out_valid & ~out_ready.
  - Transitions:
    - EMPTY + push → ONE
    - ONE + push, no pop → FULL
    - ONE + pop, no push → EMPTY
    - ONE + push + pop → ONE, with the new entry at head
    - FULL + pop → ONE
    - FULL + push cannot occur (in_ready=0)
  - When EMPTY, out_insn and out_err hold their last values (0 after reset).
- Latency:
  - Request accepted at edge N appears on out_valid/out_insn after edge N, i.e. during cycle N+1.
  - With out_ready held at 1, throughput is 1 word per cycle.
- Ordering: strict FIFO. No entry is dropped or duplicated.

Test Plan:
- BEQ: funct3=000, rs1=4, rs2=5, offset=+8 → out_insn=32'h00520463, out_err=00, one cycle after accept.
- BNE backward: funct3=001, rs1=1, rs2=2, offset=-4 (13'h1FFC) → out_insn=32'hFE209EE3, out_err=00.
- Illegal and misaligned (IALIGN=32):
  - funct3=010 → out_insn=0, out_err=01, err_count=1.
  - offset=6 with funct3=000 → out_err=10, err_count=2.
- Backpressure:
  - Hold out_ready=0 and push 3 requests back-to-back → in_ready=0 after the 2nd accept. The 3rd request is held off. out_insn stays equal to the 1st word.
  - Raise out_ready → words emerge in order 1, 2, 3.
- Streaming with out_ready=1 and in_valid=1 for 10 cycles → 10 words out, one per cycle, in order, in_ready constantly 1.
- Reset with FULL FIFO → next cycle out_valid=0, in_ready=1, err_count=0. The queued words never appear.
